// File: rtl/cnn_mac_pipe.sv
// Pipelined signed multiply-accumulate engine. Accumulates one frame of din0*din1
// products and emits a single rounded, shifted, saturated result per frame.
module cnn_mac_pipe #(
    parameter int A_WIDTH    = 10,
    parameter int B_WIDTH    = 14,
    parameter int MUL_STAGES = 2,
    parameter int ACC_WIDTH  = 32,
    parameter int SHIFT      = 6,
    parameter int OUT_WIDTH  = 16
) (
    input  logic                        ap_clk,
    input  logic                        ap_rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [A_WIDTH-1:0]   din0,
    input  logic signed [B_WIDTH-1:0]   din1,
    input  logic                        in_last,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [OUT_WIDTH-1:0] dout,
    output logic                        dout_sat
);

    localparam int P_WIDTH = A_WIDTH + B_WIDTH;
    localparam int RND_SH  = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic signed [ACC_WIDTH:0] RND = (SHIFT > 0) ?
        ($signed({{ACC_WIDTH{1'b0}}, 1'b1}) <<< RND_SH) : $signed({(ACC_WIDTH+1){1'b0}});
    localparam logic signed [ACC_WIDTH:0] OUT_MAX =
        $signed({{(ACC_WIDTH+2-OUT_WIDTH){1'b0}}, {(OUT_WIDTH-1){1'b1}}});
    localparam logic signed [ACC_WIDTH:0] OUT_MIN = ~OUT_MAX;

    logic signed [P_WIDTH-1:0]   r_prod [MUL_STAGES];
    logic [MUL_STAGES-1:0]       r_pv;
    logic [MUL_STAGES-1:0]       r_pl;
    logic signed [ACC_WIDTH-1:0] r_acc;
    logic                        r_out_valid;
    logic signed [OUT_WIDTH-1:0] r_dout;
    logic                        r_dout_sat;

    logic                        w_en;
    logic signed [P_WIDTH-1:0]   w_prod_in;
    logic signed [ACC_WIDTH-1:0] w_sum;
    logic [OUT_WIDTH:0]          w_fmt;

    // Round half up, arithmetic shift, clamp; the add is one bit wider so it cannot wrap.
    // Returns {saturated, value}.
    function automatic logic [OUT_WIDTH:0] fmt_result(input logic signed [ACC_WIDTH-1:0] sum);
        logic signed [ACC_WIDTH:0] ext;
        logic signed [ACC_WIDTH:0] shifted;
        logic [OUT_WIDTH:0]        res;
        ext     = $signed({sum[ACC_WIDTH-1], sum}) + RND;
        shifted = ext >>> SHIFT;
        if (shifted > OUT_MAX) begin
            res = {1'b1, OUT_MAX[OUT_WIDTH-1:0]};
        end else if (shifted < OUT_MIN) begin
            res = {1'b1, OUT_MIN[OUT_WIDTH-1:0]};
        end else begin
            res = {1'b0, shifted[OUT_WIDTH-1:0]};
        end
        return res;
    endfunction

    assign w_en      = !(r_out_valid && !out_ready);
    assign in_ready  = w_en;
    assign w_prod_in = din0 * din1;
    assign w_sum     = r_acc + ACC_WIDTH'(r_prod[MUL_STAGES-1]);
    assign w_fmt     = fmt_result(w_sum);

    assign out_valid = r_out_valid;
    assign dout      = r_dout;
    assign dout_sat  = r_dout_sat;

    // Product pipeline: stage 0 multiplies, later stages delay product/valid/last.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            for (int i = 0; i < MUL_STAGES; i++) begin
                r_prod[i] <= '0;
            end
            r_pv <= '0;
            r_pl <= '0;
        end else if (w_en) begin
            r_prod[0] <= w_prod_in;
            r_pv[0]   <= in_valid;
            r_pl[0]   <= in_valid & in_last;
            for (int i = 1; i < MUL_STAGES; i++) begin
                r_prod[i] <= r_prod[i-1];
                r_pv[i]   <= r_pv[i-1];
                r_pl[i]   <= r_pl[i-1];
            end
        end
    end

    // Accumulator and result register; while en=1 any held result has been accepted.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_acc       <= '0;
            r_out_valid <= 1'b0;
            r_dout      <= '0;
            r_dout_sat  <= 1'b0;
        end else if (w_en) begin
            if (r_pv[MUL_STAGES-1]) begin
                if (r_pl[MUL_STAGES-1]) begin
                    r_acc       <= '0;
                    r_out_valid <= 1'b1;
                    r_dout      <= w_fmt[OUT_WIDTH-1:0];
                    r_dout_sat  <= w_fmt[OUT_WIDTH];
                end else begin
                    r_acc       <= w_sum;
                    r_out_valid <= 1'b0;
                end
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cnn_mac_pipe.sv
// Self-checking bench for cnn_mac_pipe: frame-level reference model, per-cycle
// output monitor, directed literal cases and randomized frames with backpressure.
module tb_cnn_mac_pipe;

    localparam int A_WIDTH   = 10;
    localparam int B_WIDTH   = 14;
    localparam int SHIFT     = 6;
    localparam int OUT_WIDTH = 16;

    logic                        ap_clk = 1'b0;
    logic                        ap_rst_n;
    logic                        in_valid;
    logic                        in_ready;
    logic signed [A_WIDTH-1:0]   din0;
    logic signed [B_WIDTH-1:0]   din1;
    logic                        in_last;
    logic                        out_valid;
    logic                        out_ready;
    logic signed [OUT_WIDTH-1:0] dout;
    logic                        dout_sat;

    int     checks    = 0;
    int     failures  = 0;
    int     stall_cnt = 0;
    bit     rnd_mode  = 1'b0;

    longint m_acc = 0;
    int     exp_v[$];
    bit     exp_s[$];
    bit     prev_hold = 1'b0;
    logic signed [OUT_WIDTH-1:0] prev_dout;
    logic   prev_sat;

    cnn_mac_pipe dut (
        .ap_clk    (ap_clk),
        .ap_rst_n  (ap_rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din0      (din0),
        .din1      (din1),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout      (dout),
        .dout_sat  (dout_sat)
    );

    always #5 ap_clk = ~ap_clk;

    function automatic void chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    function automatic longint wrap32(input longint x);
        longint m;
        m = x & 64'sh0000_0000_FFFF_FFFF;
        if (m >= 64'sh0000_0000_8000_0000) m = m - 64'sh0000_0001_0000_0000;
        return m;
    endfunction

    // Reference formatting: floor((s + half) / 2^SHIFT), then clamp.
    function automatic void ref_fmt(input longint s, output int v, output bit sat);
        longint div, t, r, hi, lo;
        div = 64'sd1 <<< SHIFT;
        t   = s + div / 64'sd2;
        if (t >= 0) r = t / div;
        else        r = -((-t + div - 64'sd1) / div);
        hi = (64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (OUT_WIDTH - 1));
        if (r > hi)      begin v = int'(hi); sat = 1'b1; end
        else if (r < lo) begin v = int'(lo); sat = 1'b1; end
        else             begin v = int'(r);  sat = 1'b0; end
    endfunction

    // Monitor: handshake rule, hold stability, result compare, then model update.
    always @(negedge ap_clk) begin
        int  v;
        bit  s;
        if (!ap_rst_n) begin
            m_acc = 0;
            exp_v.delete();
            exp_s.delete();
            prev_hold = 1'b0;
        end else begin
            chk("in_ready_rule", longint'(in_ready), longint'(!(out_valid && !out_ready)));
            if (prev_hold) begin
                chk("hold_valid", longint'(out_valid), 64'sd1);
                chk("hold_dout", longint'(dout), longint'(prev_dout));
                chk("hold_sat", longint'(dout_sat), longint'(prev_sat));
            end
            if (out_valid && out_ready) begin
                if (exp_v.size() == 0) begin
                    chk("unexpected_result", longint'(dout), 64'sd999999);
                end else begin
                    v = exp_v.pop_front();
                    s = exp_s.pop_front();
                    chk("result_dout", longint'(dout), longint'(v));
                    chk("result_sat", longint'(dout_sat), longint'(s));
                end
            end
            if (in_valid && in_ready) begin
                m_acc = wrap32(m_acc + longint'(din0) * longint'(din1));
                if (in_last) begin
                    ref_fmt(m_acc, v, s);
                    exp_v.push_back(v);
                    exp_s.push_back(s);
                    m_acc = 0;
                end
            end
            prev_hold = out_valid && !out_ready;
            prev_dout = dout;
            prev_sat  = dout_sat;
        end
    end

    task automatic tick();
        @(posedge ap_clk);
        #1;
        if (rnd_mode) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send(input int a, input int b, input bit last);
        bit ok;
        int n;
        in_valid = 1'b1;
        din0     = A_WIDTH'(a);
        din1     = B_WIDTH'(b);
        in_last  = last;
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 200) begin
            @(negedge ap_clk);
            ok = in_ready;
            if (!ok) stall_cnt++;
            tick();
            n++;
        end
        if (!ok) chk("send_timeout", 64'sd0, 64'sd1);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        din0     = A_WIDTH'($urandom);
        din1     = B_WIDTH'($urandom);
        in_last  = 1'($urandom_range(0, 1));
        tick();
        in_last  = 1'b0;
    endtask

    task automatic wait_result(input string name, input int ev, input bit es);
        int n;
        n = 0;
        @(negedge ap_clk);
        while (!out_valid && n < 30) begin
            @(negedge ap_clk);
            n++;
        end
        chk({name, "_valid"}, longint'(out_valid), 64'sd1);
        chk({name, "_dout"}, longint'(dout), longint'(ev));
        chk({name, "_sat"}, longint'(dout_sat), longint'(es));
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        ap_rst_n = 1'b0;
        in_valid = 1'b0;
        din0 = '0;
        din1 = '0;
        in_last = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge ap_clk);
        chk("rst_out_valid", longint'(out_valid), 64'sd0);
        chk("rst_dout", longint'(dout), 64'sd0);
        chk("rst_sat", longint'(dout_sat), 64'sd0);
        @(posedge ap_clk);
        #1;
        ap_rst_n = 1'b1;
        @(negedge ap_clk);
        chk("post_rst_in_ready", longint'(in_ready), 64'sd1);
        tick();

        // Latency: accepted at E0, valid after E0+2.
        send(64, 64, 1'b1);
        @(negedge ap_clk);
        chk("lat_e0", longint'(out_valid), 64'sd0);
        @(negedge ap_clk);
        chk("lat_e1", longint'(out_valid), 64'sd0);
        @(negedge ap_clk);
        chk("lat_e2", longint'(out_valid), 64'sd1);
        chk("lat_dout", longint'(dout), 64'sd64);
        chk("lat_sat", longint'(dout_sat), 64'sd0);
        tick();

        send(1, 32, 1'b1);   wait_result("rnd_1_32", 1, 1'b0);
        send(1, 31, 1'b1);   wait_result("rnd_1_31", 0, 1'b0);
        send(-1, 32, 1'b1);  wait_result("rnd_m1_32", 0, 1'b0);
        send(-1, 33, 1'b1);  wait_result("rnd_m1_33", -1, 1'b0);

        for (int i = 0; i < 4; i++) send(-512, 8191, (i == 3));
        wait_result("sat_neg", -32768, 1'b1);
        send(2, 64, 1'b1);   wait_result("sat_clear", 2, 1'b0);

        // Backpressure: result held while a 3-beat frame is stuck behind it.
        out_ready = 1'b0;
        fork
            begin
                send(3, 64, 1'b1);
                send(10, 64, 1'b0);
                send(10, 64, 1'b0);
                send(10, 64, 1'b1);
            end
            begin
                repeat (10) @(negedge ap_clk);
                chk("bp_in_ready", longint'(in_ready), 64'sd0);
                chk("bp_out_valid", longint'(out_valid), 64'sd1);
                chk("bp_dout", longint'(dout), 64'sd3);
                @(posedge ap_clk);
                #1;
                out_ready = 1'b1;
            end
        join
        wait_result("bp_second", 30, 1'b0);

        // Reset mid-frame discards the partial sum.
        send(100, 100, 1'b0);
        send(100, 100, 1'b0);
        ap_rst_n = 1'b0;
        @(negedge ap_clk);
        chk("midrst_valid", longint'(out_valid), 64'sd0);
        chk("midrst_dout", longint'(dout), 64'sd0);
        @(posedge ap_clk);
        #1;
        ap_rst_n = 1'b1;
        tick();
        send(2, 64, 1'b1);   wait_result("midrst_after", 2, 1'b0);

        // Back-to-back frames of 1,1,3,1 beats.
        stall_cnt = 0;
        send(1, 64, 1'b1);
        send(2, 64, 1'b1);
        send(3, 64, 1'b0);
        send(4, 64, 1'b0);
        send(5, 64, 1'b1);
        send(-7, 64, 1'b1);
        chk("b2b_stalls", longint'(stall_cnt), 64'sd0);
        repeat (4) idle();
        chk("b2b_drained", longint'(exp_v.size()), 64'sd0);

        // Randomized frames with random backpressure and idle gaps.
        rnd_mode = 1'b1;
        for (int f = 0; f < 80; f++) begin
            int len;
            len = $urandom_range(1, 6);
            for (int b = 0; b < len; b++) begin
                int a, c;
                if ($urandom_range(0, 1) == 0) begin
                    a = int'($urandom_range(0, 1023)) - 512;
                    c = int'($urandom_range(0, 16383)) - 8192;
                end else begin
                    a = int'($urandom_range(0, 40)) - 20;
                    c = int'($urandom_range(0, 400)) - 200;
                end
                send(a, c, (b == len - 1));
                if ($urandom_range(0, 3) == 0) idle();
            end
        end
        rnd_mode  = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while ((exp_v.size() != 0 || out_valid) && n < 100) begin
            idle();
            n++;
        end
        chk("final_drain", longint'(exp_v.size()), 64'sd0);
        chk("final_out_valid", longint'(out_valid), 64'sd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
